mem_copy_engine: RTL and testbench

Memory-side initiator that copies a block of 64-bit doublewords from one byte address range of the data memory to another. It sits on the master end of the data-memory port and drives Mem_Addr, Write_Data, Mem_Write and Mem_Read. It consumes Read_Data from the memory. A control side lets a host start, abort and monitor a transfer.

---
 rtl/mem_copy_engine_if.sv | 22 ++
 rtl/mem_copy_engine.sv | 119 +++++++++++
 tb/tb_mem_copy_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Data-memory port bundle: the copy engine drives address/data/enables and
// the memory returns combinational read data.
interface mem_copy_engine_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data;
  logic              Mem_Write;
  logic              Mem_Read;
  logic [DATA_W-1:0] Read_Data;

  modport master (
    output Mem_Addr, Write_Data, Mem_Write, Mem_Read,
    input  Read_Data
  );

  modport slave (
    input  Mem_Addr, Write_Data, Mem_Write, Mem_Read,
    output Read_Data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy of doublewords from one memory range to another, one word per
// READ/WRITE cycle pair, with abort, misalignment flag and progress count.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_W-1:0]     words_copied,
  mem_copy_engine_if.master    mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic                err_q, err_d;
  logic                misaligned;

  assign misaligned = (src_addr[2:0] != 3'b000) || (dst_addr[2:0] != 3'b000);

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    len_d     = len_q;
    rd_buf_d  = rd_buf_q;
    words_d   = words_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          len_d     = length;
          words_d   = '0;
          err_d     = misaligned;
          state_d   = (misaligned || (length == '0)) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rd_buf_d = mem.Read_Data;
        state_d  = abort ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // The write in flight always lands and is counted, even on abort.
        words_d   = words_q + LEN_W'(1);
        src_ptr_d = src_ptr_q + ADDR_W'(8);
        dst_ptr_d = dst_ptr_q + ADDR_W'(8);
        state_d   = ((words_d == len_q) || abort) ? S_DONE : S_READ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.Mem_Addr   = '0;
    mem.Write_Data = '0;
    mem.Mem_Write  = 1'b0;
    mem.Mem_Read   = 1'b0;
    case (state_q)
      S_READ: begin
        mem.Mem_Addr = src_ptr_q;
        mem.Mem_Read = 1'b1;
      end
      S_WRITE: begin
        mem.Mem_Addr   = dst_ptr_q;
        mem.Write_Data = rd_buf_q;
        mem.Mem_Write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q == S_READ) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;
  assign words_copied = words_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      len_q     <= '0;
      rd_buf_q  <= '0;
      words_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      len_q     <= len_d;
      rd_buf_q  <= rd_buf_d;
      words_q   <= words_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 32-doubleword memory model
// indexed by Mem_Addr[7:3].
module tb_mem_copy_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] src_addr;
  logic [63:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_copied;

  logic [63:0] mem [32];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [63:0] pl_data;

  int unsigned checks;
  int unsigned errors;

  mem_copy_engine_if #(.ADDR_W(64), .DATA_W(64)) mif ();

  mem_copy_engine #(.ADDR_W(64), .DATA_W(64), .LEN_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_copied (words_copied),
    .mem          (mif.master)
  );

  always #5 clk = ~clk;

  assign mif.Read_Data = mem[mif.Mem_Addr[7:3]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mif.Mem_Write) mem[mif.Mem_Addr[7:3]] <= mif.Write_Data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic poke(input int unsigned idx, input logic [63:0] d);
    pl_idx  = 5'(idx);
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  // Returns in cycle 1 of the transfer (start accepted at edge 0).
  task automatic go(input logic [63:0] s, input logic [63:0] d, input logic [15:0] n);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rd"},   64'(mif.Mem_Read), 64'd0);
    chk({tag, "_wr"},   64'(mif.Mem_Write), 64'd0);
    chk({tag, "_addr"}, mif.Mem_Addr, 64'd0);
    chk({tag, "_wdata"}, mif.Write_Data, 64'd0);
  endtask

  initial begin
    logic [63:0] ea [6];
    logic [63:0] ed [3];
    ea = '{64'd0, 64'd64, 64'd8, 64'd72, 64'd16, 64'd80};
    ed = '{64'd10, 64'd4, 64'd7};
    checks = 0;
    errors = 0;
    clk = 1'b0; reset = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;

    // Reset then idle
    tick();
    tick();
    reset = 1'b1;
    chk_quiet("rst");
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_words", 64'(words_copied), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet("idle");
    end
    for (int unsigned i = 0; i < 32; i++) poke(i, 64'd0);

    // Basic copy: 3 words from 0 to 64
    poke(0, 64'd10);
    poke(1, 64'd4);
    poke(2, 64'd7);
    go(64'd0, 64'd64, 16'd3);
    for (int c = 1; c <= 6; c++) begin
      chk("basic_addr", mif.Mem_Addr, ea[c-1]);
      chk("basic_rd", 64'(mif.Mem_Read), 64'(c % 2));
      chk("basic_wr", 64'(mif.Mem_Write), 64'((c + 1) % 2));
      chk("basic_busy", 64'(busy), 64'd1);
      chk("basic_done_early", 64'(done), 64'd0);
      if (c % 2 == 0) chk("basic_wdata", mif.Write_Data, ed[c/2-1]);
      tick();
    end
    chk("basic_done7", 64'(done), 64'd1);
    chk("basic_busy7", 64'(busy), 64'd0);
    chk("basic_words", 64'(words_copied), 64'd3);
    tick();
    chk("basic_done8", 64'(done), 64'd0);
    chk("basic_words_hold", 64'(words_copied), 64'd3);
    chk("basic_mem64", mem[8], 64'd10);
    chk("basic_mem72", mem[9], 64'd4);
    chk("basic_mem80", mem[10], 64'd7);

    // Zero length
    go(64'd0, 64'd64, 16'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_err", 64'(err), 64'd0);
    chk("zero_words", 64'(words_copied), 64'd0);
    chk("zero_rd", 64'(mif.Mem_Read), 64'd0);
    chk("zero_wr", 64'(mif.Mem_Write), 64'd0);
    tick();

    // Misaligned source
    go(64'd4, 64'd64, 16'd2);
    chk("mis_done", 64'(done), 64'd1);
    chk("mis_err", 64'(err), 64'd1);
    chk("mis_rd", 64'(mif.Mem_Read), 64'd0);
    chk("mis_wr", 64'(mif.Mem_Write), 64'd0);
    tick();
    chk("mis_err_hold", 64'(err), 64'd1);
    chk_quiet("mis_idle");

    // Aligned start clears err
    go(64'd0, 64'd200, 16'd1);
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_rd", 64'(mif.Mem_Read), 64'd1);
    tick();
    tick();
    chk("clr_done", 64'(done), 64'd1);
    tick();
    chk("clr_mem", mem[25], 64'd10);

    // Abort during WRITE of word 1
    poke(3, 64'd99);
    go(64'd0, 64'd128, 16'd4);
    tick();
    tick();
    tick();
    abort = 1'b1;
    chk("abw_wr", 64'(mif.Mem_Write), 64'd1);
    chk("abw_addr", mif.Mem_Addr, 64'd136);
    tick();
    abort = 1'b0;
    chk("abw_done", 64'(done), 64'd1);
    chk("abw_words", 64'(words_copied), 64'd2);
    tick();
    chk("abw_mem0", mem[16], 64'd10);
    chk("abw_mem1", mem[17], 64'd4);
    chk("abw_mem2", mem[18], 64'd0);
    chk("abw_mem3", mem[19], 64'd0);

    // Abort during READ of word 1
    go(64'd0, 64'd208, 16'd3);
    tick();
    tick();
    abort = 1'b1;
    chk("abr_rd", 64'(mif.Mem_Read), 64'd1);
    tick();
    abort = 1'b0;
    chk("abr_done", 64'(done), 64'd1);
    chk("abr_wr", 64'(mif.Mem_Write), 64'd0);
    chk("abr_words", 64'(words_copied), 64'd1);
    tick();
    chk("abr_mem0", mem[26], 64'd10);
    chk("abr_mem1", mem[27], 64'd0);

    // Start while busy is ignored
    go(64'd0, 64'd96, 16'd3);
    tick();
    tick();
    src_addr = 64'd8; dst_addr = 64'd224; length = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_addr4", mif.Mem_Addr, 64'd104);
    tick();
    tick();
    tick();
    chk("sb_done", 64'(done), 64'd1);
    chk("sb_words", 64'(words_copied), 64'd3);
    tick();
    chk("sb_mem0", mem[12], 64'd10);
    chk("sb_mem1", mem[13], 64'd4);
    chk("sb_mem2", mem[14], 64'd7);
    chk("sb_mem_other", mem[28], 64'd0);

    // Reset mid-transfer in cycle 4 (WRITE of word 1)
    go(64'd0, 64'd240, 16'd3);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_quiet("mrst");
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_words", 64'(words_copied), 64'd0);
    chk("mrst_mem_commit", mem[31], 64'd4);
    reset = 1'b1;
    tick();
    chk_quiet("mrst_idle");

    // Wrap-around of source pointer
    poke(31, 64'h55);
    go(64'hFFFF_FFFF_FFFF_FFF8, 64'd152, 16'd2);
    chk("wrap_addr1", mif.Mem_Addr, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("wrap_wdata1", mif.Write_Data, 64'h55);
    tick();
    chk("wrap_addr3", mif.Mem_Addr, 64'd0);
    chk("wrap_rd3", 64'(mif.Mem_Read), 64'd1);
    tick();
    chk("wrap_wdata2", mif.Write_Data, 64'd10);
    tick();
    chk("wrap_done", 64'(done), 64'd1);
    chk("wrap_words", 64'(words_copied), 64'd2);
    tick();
    chk("wrap_mem0", mem[19], 64'h55);
    chk("wrap_mem1", mem[20], 64'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
